// File: rtl/getir1_pkg.sv
// Shared constants and state encodings for the getir1 fetch stage.
package getir1_pkg;

    localparam int              G1_PS_BIT          = 32;
    localparam int              G1_KUYRUK_DERINLIK = 4;
    localparam logic [31:0]     G1_BASLANGIC_PS    = 32'h4000_0000;

    // YONLENDIR marks the single cycle that follows an accepted redirect.
    typedef enum logic {
        G1_CALIS     = 1'b0,
        G1_YONLENDIR = 1'b1
    } g1_durum_t;

endpackage

// File: rtl/getir1_if.sv
// Fetch-stage bundle: L1B request channel, getir2 PS channel and redirect/stall controls.
interface getir1_if #(
    parameter int PS_BIT = 32
);
    logic [PS_BIT-1:0] l1b_istek_ps_o;
    logic              l1b_istek_gecerli_o;
    logic              l1b_istek_hazir_i;
    logic              g2_istek_yapildi_o;
    logic [PS_BIT-1:0] g2_ps_o;
    logic              g2_ps_gecerli_o;
    logic              g2_ps_hazir_i;
    logic [PS_BIT-1:0] g2_dallanma_ps_i;
    logic              g2_dallanma_gecerli_i;
    logic [PS_BIT-1:0] yurut_bosalt_ps_i;
    logic              cek_bosalt_i;
    logic              cek_duraklat_i;

    modport master (
        output l1b_istek_ps_o, l1b_istek_gecerli_o, g2_istek_yapildi_o,
               g2_ps_o, g2_ps_gecerli_o,
        input  l1b_istek_hazir_i, g2_ps_hazir_i, g2_dallanma_ps_i,
               g2_dallanma_gecerli_i, yurut_bosalt_ps_i, cek_bosalt_i, cek_duraklat_i
    );

    modport slave (
        input  l1b_istek_ps_o, l1b_istek_gecerli_o, g2_istek_yapildi_o,
               g2_ps_o, g2_ps_gecerli_o,
        output l1b_istek_hazir_i, g2_ps_hazir_i, g2_dallanma_ps_i,
               g2_dallanma_gecerli_i, yurut_bosalt_ps_i, cek_bosalt_i, cek_duraklat_i
    );
endinterface

// File: rtl/getir1_ps_kuyrugu.sv
// In-order PS queue: show-ahead synchronous FIFO whose flush overrides push and pop.
module getir1_ps_kuyrugu #(
    parameter int GENISLIK = 32,
    parameter int DERINLIK = 4
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [GENISLIK-1:0] push_data,
    output logic                full,
    output logic                empty,
    output logic [GENISLIK-1:0] head
);
    localparam int AW = $clog2(DERINLIK);

    logic [GENISLIK-1:0] mem [DERINLIK];
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [AW:0]         count_reg;
    logic                push_ok;
    logic                pop_ok;

    assign full    = (count_reg == (AW+1)'(DERINLIK));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !flush && !srst;
    assign pop_ok  = pop && !empty && !flush;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    doluluk_sinir: assert property (@(posedge clk) disable iff (srst)
        count_reg <= (AW+1)'(DERINLIK));

endmodule

// File: rtl/getir1.sv
// First fetch stage: generates the fetch PS, issues L1B requests and tracks them in order.
// Optional performance counters are enabled with GETIR1_BASARIM_SAYAC_EN.
module getir1
    import getir1_pkg::*;
#(
    parameter int              PS_BIT          = G1_PS_BIT,
    parameter int              KUYRUK_DERINLIK = G1_KUYRUK_DERINLIK,
    parameter logic [PS_BIT-1:0] BASLANGIC_PS  = G1_BASLANGIC_PS
) (
    input  logic     clk_i,
    input  logic     rst_i,
    getir1_if.master bus
`ifdef GETIR1_BASARIM_SAYAC_EN
    ,
    output logic [31:0] basarim_istek_sayisi_o,
    output logic [31:0] basarim_yonlendirme_sayisi_o
`endif
);
    g1_durum_t         state_reg, state_next;
    logic [PS_BIT-1:0] siradaki_ps_reg, siradaki_ps_next;
    logic [PS_BIT-1:0] hizali_ps;
    logic              redirect;
    logic              istek_gecerli;
    logic              handshake;
    logic              pop;
    logic              kuyruk_dolu;
    logic              kuyruk_bos;

    assign hizali_ps     = {siradaki_ps_reg[PS_BIT-1:2], 2'b00};
    assign redirect      = (bus.cek_bosalt_i || bus.g2_dallanma_gecerli_i) && !bus.cek_duraklat_i;
    // Valid is independent of hazir so L1B may wait on it without a combinational loop.
    assign istek_gecerli = !kuyruk_dolu && !bus.cek_duraklat_i && !redirect && !rst_i;
    assign handshake     = istek_gecerli && bus.l1b_istek_hazir_i;
    assign pop           = !kuyruk_bos && bus.g2_ps_hazir_i && !bus.cek_duraklat_i;

    assign bus.l1b_istek_ps_o      = hizali_ps;
    assign bus.l1b_istek_gecerli_o = istek_gecerli;
    assign bus.g2_istek_yapildi_o  = handshake;
    assign bus.g2_ps_gecerli_o     = !kuyruk_bos;

    getir1_ps_kuyrugu #(
        .GENISLIK (PS_BIT),
        .DERINLIK (KUYRUK_DERINLIK)
    ) u_ps_kuyrugu (
        .clk       (clk_i),
        .srst      (rst_i),
        .push      (handshake),
        .pop       (pop),
        .flush     (redirect),
        .push_data (siradaki_ps_reg),
        .full      (kuyruk_dolu),
        .empty     (kuyruk_bos),
        .head      (bus.g2_ps_o)
    );

    // Execute redirect outranks the predictor; the unaligned target bits are kept.
    always_comb begin
        siradaki_ps_next = siradaki_ps_reg;
        if (redirect && bus.cek_bosalt_i) begin
            siradaki_ps_next = bus.yurut_bosalt_ps_i;
        end else if (redirect) begin
            siradaki_ps_next = bus.g2_dallanma_ps_i;
        end else if (handshake) begin
            siradaki_ps_next = hizali_ps + PS_BIT'(4);
        end
    end

    always_comb begin
        state_next = G1_CALIS;
        case (state_reg)
            G1_CALIS:     state_next = redirect ? G1_YONLENDIR : G1_CALIS;
            G1_YONLENDIR: state_next = G1_CALIS;
            default:      state_next = G1_CALIS;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= G1_CALIS;
            siradaki_ps_reg <= BASLANGIC_PS;
        end else begin
            state_reg       <= state_next;
            siradaki_ps_reg <= siradaki_ps_next;
        end
    end

`ifdef GETIR1_BASARIM_SAYAC_EN
    logic [31:0] istek_sayisi_reg;
    logic [31:0] yonlendirme_sayisi_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            istek_sayisi_reg       <= '0;
            yonlendirme_sayisi_reg <= '0;
        end else begin
            if (handshake) istek_sayisi_reg <= istek_sayisi_reg + 32'd1;
            if (state_reg == G1_CALIS && state_next == G1_YONLENDIR) begin
                yonlendirme_sayisi_reg <= yonlendirme_sayisi_reg + 32'd1;
            end
        end
    end

    assign basarim_istek_sayisi_o       = istek_sayisi_reg;
    assign basarim_yonlendirme_sayisi_o = yonlendirme_sayisi_reg;
`endif

endmodule

// File: tb/tb_getir1.sv
// Scoreboard bench for getir1: expected requests queued with stimulus, checked at handshake and pop.
module tb_getir1;
    logic clk = 1'b0;
    logic rst;

    getir1_if #(.PS_BIT(32)) bus ();

`ifdef GETIR1_BASARIM_SAYAC_EN
    logic [31:0] ist_say;
    logic [31:0] yon_say;
`endif

    getir1 dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef GETIR1_BASARIM_SAYAC_EN
        ,
        .basarim_istek_sayisi_o       (ist_say),
        .basarim_yonlendirme_sayisi_o (yon_say)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_ps_q[$];
    logic [31:0] kuyruk_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, req);
        end
    endtask

    task automatic beklenen(input logic [31:0] addr, input logic [31:0] ps);
        exp_addr_q.push_back(addr);
        exp_ps_q.push_back(ps);
    endtask

    task automatic drain(input string tag);
        check(tag, 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_ps_q.delete();
    endtask

    // One clock: sample #1 after the driving negedge, then advance to the next negedge.
    task automatic tick();
        logic redir;
        logic [31:0] a;
        logic [31:0] p;
        #1;
        redir = (bus.cek_bosalt_i || bus.g2_dallanma_gecerli_i) && !bus.cek_duraklat_i;
        if (rst) begin
            check("rst_gecerli", 32'(bus.l1b_istek_gecerli_o), 32'd0);
            check("rst_yapildi", 32'(bus.g2_istek_yapildi_o), 32'd0);
        end else begin
            check("g2_gecerli", 32'(bus.g2_ps_gecerli_o), 32'(kuyruk_q.size() != 0));
            if (bus.g2_ps_gecerli_o && bus.g2_ps_hazir_i && !bus.cek_duraklat_i && !redir
                && kuyruk_q.size() != 0) begin
                p = kuyruk_q.pop_front();
                $display("POP ps=%h", bus.g2_ps_o);
                check("g2_ps", bus.g2_ps_o, p);
            end
            if (bus.l1b_istek_gecerli_o && bus.l1b_istek_hazir_i) begin
                $display("REQ addr=%h", bus.l1b_istek_ps_o);
                check("yapildi", 32'(bus.g2_istek_yapildi_o), 32'd1);
                if (exp_addr_q.size() == 0) begin
                    check("req_extra", 32'(exp_addr_q.size()), 32'd1);
                end else begin
                    a = exp_addr_q.pop_front();
                    p = exp_ps_q.pop_front();
                    check("req_addr", bus.l1b_istek_ps_o, a);
                    kuyruk_q.push_back(p);
                end
            end else begin
                check("yapildi_idle", 32'(bus.g2_istek_yapildi_o), 32'd0);
            end
        end
        @(posedge clk);
        if (rst || redir) kuyruk_q.delete();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.l1b_istek_hazir_i     = 1'b1;
        bus.g2_ps_hazir_i         = 1'b0;
        bus.g2_dallanma_ps_i      = '0;
        bus.g2_dallanma_gecerli_i = 1'b0;
        bus.yurut_bosalt_ps_i     = '0;
        bus.cek_bosalt_i          = 1'b0;
        bus.cek_duraklat_i        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_g2_gecerli", 32'(bus.g2_ps_gecerli_o), 32'd0);
        check("reset_ps", bus.l1b_istek_ps_o, 32'h4000_0000);

        // Fill the queue with no consumer.
        for (int i = 0; i < 4; i++) beklenen(32'h4000_0000 + 32'(4 * i), 32'h4000_0000 + 32'(4 * i));
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("dolu_gecerli", 32'(bus.l1b_istek_gecerli_o), 32'd0);
        check("dolu_head", bus.g2_ps_o, 32'h4000_0000);
        tick();
        drain("fill_drain");

        // Steady state: pop and push every cycle once a slot frees.
        bus.g2_ps_hazir_i = 1'b1;
        for (int i = 0; i < 6; i++) beklenen(32'h4000_0010 + 32'(4 * i), 32'h4000_0010 + 32'(4 * i));
        for (int i = 0; i < 7; i++) tick();
        drain("steady_drain");

        // Predictor redirect to an unaligned target.
        bus.g2_dallanma_gecerli_i = 1'b1;
        bus.g2_dallanma_ps_i      = 32'h4000_0102;
        tick();
        bus.g2_dallanma_gecerli_i = 1'b0;
        #1;
        check("dallanma_bos", 32'(bus.g2_ps_gecerli_o), 32'd0);
        check("dallanma_addr", bus.l1b_istek_ps_o, 32'h4000_0100);
        beklenen(32'h4000_0100, 32'h4000_0102);
        beklenen(32'h4000_0104, 32'h4000_0104);
        tick();
        tick();
        bus.l1b_istek_hazir_i = 1'b0;
        tick();
        #1;
        check("hold_gecerli", 32'(bus.l1b_istek_gecerli_o), 32'd1);
        check("hold_addr", bus.l1b_istek_ps_o, 32'h4000_0108);
        drain("dallanma_drain");

        // Execute flush wins over a simultaneous predictor redirect.
        bus.l1b_istek_hazir_i     = 1'b1;
        bus.cek_bosalt_i          = 1'b1;
        bus.yurut_bosalt_ps_i     = 32'h8000_0000;
        bus.g2_dallanma_gecerli_i = 1'b1;
        bus.g2_dallanma_ps_i      = 32'h4000_0200;
        tick();
        bus.cek_bosalt_i          = 1'b0;
        bus.g2_dallanma_gecerli_i = 1'b0;
        beklenen(32'h8000_0000, 32'h8000_0000);
        beklenen(32'h8000_0004, 32'h8000_0004);
        tick();
        tick();
        drain("oncelik_drain");

        // Stall holds everything, including a pending redirect.
        bus.cek_duraklat_i        = 1'b1;
        bus.g2_dallanma_gecerli_i = 1'b1;
        bus.g2_dallanma_ps_i      = 32'h4000_0300;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_gecerli", 32'(bus.l1b_istek_gecerli_o), 32'd0);
            check("stall_head", bus.g2_ps_o, 32'h8000_0004);
            check("stall_ps", bus.l1b_istek_ps_o, 32'h8000_0008);
            tick();
        end
        bus.cek_duraklat_i = 1'b0;
        tick();
        bus.g2_dallanma_gecerli_i = 1'b0;
        beklenen(32'h4000_0300, 32'h4000_0300);
        tick();
        bus.l1b_istek_hazir_i = 1'b0;
        tick();
        drain("stall_drain");

        // Wrap at the top of the address space, then reset mid-stream.
        bus.cek_bosalt_i      = 1'b1;
        bus.yurut_bosalt_ps_i = 32'hFFFF_FFFC;
        bus.g2_ps_hazir_i     = 1'b0;
        tick();
        bus.cek_bosalt_i      = 1'b0;
        bus.l1b_istek_hazir_i = 1'b1;
        beklenen(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        beklenen(32'h0000_0000, 32'h0000_0000);
        tick();
        tick();
        drain("wrap_drain");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_bos", 32'(bus.g2_ps_gecerli_o), 32'd0);
        check("midrst_ps", bus.l1b_istek_ps_o, 32'h4000_0000);
        beklenen(32'h4000_0000, 32'h4000_0000);
        tick();
        bus.l1b_istek_hazir_i = 1'b0;
        tick();
        drain("final_drain");

`ifdef GETIR1_BASARIM_SAYAC_EN
        check("perf_istek", ist_say, 32'd1);
        check("perf_yon", yon_say, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/getir1.md
Name: getir1

Overview:
- First fetch stage, directly upstream of getir2.
- Generates the fetch program counter (PS) and issues word-aligned requests to the L1 instruction cache (L1B).
- Records each issued PS in an in-order queue and presents the queue head to getir2 as the PS matching the next L1B response.
- Applies redirects from execute (flush) and from getir2's branch predictor.

Parameters:
- PS_BIT, 32, program counter width.
- KUYRUK_DERINLIK, 4, max outstanding requests / PS queue entries; power of two, ≥2.
- BASLANGIC_PS, 32'h4000_0000, PS after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- l1b_istek_ps_o  out  PS_BIT  request address, always PS with bits [1:0] = 0.
- l1b_istek_gecerli_o  out  1  request valid.
- l1b_istek_hazir_i  in  1  L1B accepts request.
- g2_istek_yapildi_o  out  1  pulses in the cycle an L1B request handshake completes.
- g2_ps_o  out  PS_BIT  queue-head PS, unaligned bits preserved.
- g2_ps_gecerli_o  out  1  queue non-empty.
- g2_ps_hazir_i  in  1  getir2 consumes the head.
- g2_dallanma_ps_i  in  PS_BIT  predicted target.
- g2_dallanma_gecerli_i  in  1  predictor redirect.
- yurut_bosalt_ps_i  in  PS_BIT  execute redirect target.
- cek_bosalt_i  in  1  pipeline flush / execute redirect.
- cek_duraklat_i  in  1  pipeline stall.

Behaviour:
- **Reset** (rst_i high at posedge):
  - siradaki_ps_r = BASLANGIC_PS.
  - Queue empty; occupancy = 0.
  - All valid outputs 0.
  - Reset mid-operation discards all in-flight state.
- **Request issue**:
  - l1b_istek_gecerli_o = !kuyruk_dolu && !cek_duraklat_i && !redirect_w && !rst_i.
  - redirect_w = (cek_bosalt_i || g2_dallanma_gecerli_i) && !cek_duraklat_i.
  - gecerli never depends on hazir. Once raised, address is held stable until handshake or redirect.
  - l1b_istek_ps_o = siradaki_ps_r & ~3.
- **On handshake**:
  - Push siradaki_ps_r (full, unaligned) into the queue.
  - siradaki_ps_r ← (siradaki_ps_r & ~3) + 4, mod 2^PS_BIT (wraps to 0).
  - g2_istek_yapildi_o = 1 for that cycle only. It is combinational with the handshake and is never asserted during reset or redirect.
- **Queue pop**:
  - g2_ps_gecerli_o && g2_ps_hazir_i pops the head.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Full queue: no push, even if a pop occurs that cycle.
  - Empty queue: g2_ps_gecerli_o = 0; hazir is ignored.
- **Redirect priority**: cek_bosalt_i (execute) > g2_dallanma_gecerli_i > sequential.
  - Both redirects are honoured only when !cek_duraklat_i. During a stall, siradaki_ps_r, the queue and all outputs hold.
- **On redirect cycle**:
  - Queue flushed; occupancy = 0. Any same-cycle pop or push is discarded; flush wins.
  - siradaki_ps_r ← chosen target, unaligned bits kept.
  - No request issued that cycle.
  - First request at the target issues at the earliest in the next cycle (1-cycle redirect bubble).
- **Stale responses**: getir2 discards responses for requests issued before the flush using its own counters. getir1 does not track them.
- **State**:
  - States: CALIS (normal) and YONLENDIR (one-cycle post-redirect marker).
  - YONLENDIR returns to CALIS unconditionally the next cycle.
  - The marker is used only by the optional feature below; functional issue logic depends solely on signals above.
- **Occupancy counter**: width $clog2(KUYRUK_DERINLIK)+1. Must never exceed KUYRUK_DERINLIK or underflow; an assertion is provided.

Optional Feature:
- Macro GETIR1_BASARIM_SAYAC_EN.
- **Defined**: adds outputs basarim_istek_sayisi_o [31:0] and basarim_yonlendirme_sayisi_o [31:0].
  - basarim_istek_sayisi_o counts L1B handshakes.
  - basarim_yonlendirme_sayisi_o counts redirect cycles (entries into YONLENDIR).
  - Both reset to 0, wrap at 2^32 and hold during stall.
- **Undefined**: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared header sabitler.vh supplies `PS_BIT, `HIGH/`LOW.
- Add there: G1_CALIS/G1_YONLENDIR state encodings and the `BASLANGIC_PS default.
- One sub-module: ps_kuyrugu.
  - Synchronous FIFO with width PS_BIT and depth KUYRUK_DERINLIK.
  - Interface: push, pop, flush, full, empty, head.
  - Flush has priority over push and pop.

Test Plan:
1. Reset release, l1b_istek_hazir_i=1, g2_ps_hazir_i=0 → requests 0x4000_0000, 0x4000_0004, 0x4000_0008, 0x4000_000C; then gecerli drops (queue full, 4); g2_ps_o=0x4000_0000.
2. Steady state, hazir both 1 → one request per cycle; g2_istek_yapildi_o high every cycle; occupancy stays constant.
3. g2_dallanma_gecerli_i=1, target 0x4000_0102 → queue empties the next cycle; following request address 0x4000_0100; g2_ps_o=0x4000_0102; next request 0x4000_0104.
4. cek_bosalt_i and g2_dallanma_gecerli_i in the same cycle, targets 0x8000_0000/0x4000_0200 → next request 0x8000_0000.
5. cek_duraklat_i=1 for 3 cycles with redirect asserted → no request, no pop, queue and siradaki_ps_r unchanged; redirect taken in the first unstalled cycle.
6. siradaki_ps_r = 0xFFFF_FFFC, handshake → next request 0x0000_0000; rst_i asserted mid-stream → queue empty and request at BASLANGIC_PS the cycle after release.
